alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Registered integer ALU for the simple CPU datapath; sits between the register-file read ports and the writeback/memory-address/branch logic.
- Computes one result per cycle from two DATAWIDTH operands and a 4-bit opcode.
- Address-forming ops (LW, SW, JMP, branches, LI) produce a_i + b_i.
- Also provides a branch-condition flag and status flags.

Parameters:
- DATAWIDTH, 32, operand and result width in bits (legal range ≥ 8).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- a_i  in  DATAWIDTH  operand A
- b_i  in  DATAWIDTH  operand B
- opcode_i  in  4  operation select
- out_o  out  DATAWIDTH  registered result
- cond_o  out  1  registered branch condition (BEQ/BGT/BGE), else 0
- zero_o  out  1  registered: result equals 0
- div_zero_o  out  1  registered: DIV issued with b_i == 0

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- All outputs are flops updated on the rising edge of clk. Latency is exactly 1 cycle from inputs to outputs. There is no handshake: a new operation is accepted every cycle.
- Reset (rst=1 at an edge): out_o=0, cond_o=0, zero_o=0, div_zero_o=0. Reset has priority over any operation in flight; the operation sampled in that cycle is discarded.
- Opcode encoding and result (all arithmetic modulo 2^DATAWIDTH):
  - 0 ADD: a+b
  - 1 SUB: a-b (two's complement wrap)
  - 2 MUL: low DATAWIDTH bits of a*b
  - 3 DIV: unsigned a/b, truncating
  - 4 AND: a&b
  - 5 OR: a|b
  - 6 XOR: a^b
  - 7 LW: a+b
  - 8 SW: a+b
  - 9 JMP: a+b
  - 10 BEQ: a+b
  - 11 BGT: a+b
  - 12 BGE: a+b
  - 13 LI: a+b
  - 14, 15: reserved; out_o=0 and all flags 0
- Overflow/carry is not reported; results wrap silently.
- DIV by zero: out_o = all ones; div_zero_o=1. div_zero_o=0 for every other case.
- cond_o uses signed two's-complement comparison of a_i and b_i:
  - BEQ: a==b
  - BGT: a>b
  - BGE: a>=b
  - all other opcodes: 0
- zero_o = (next out_o == 0), evaluated for every opcode including reserved ones. It is 0 while in reset.
- Inputs are sampled only at the clock edge; changes between edges have no effect. An X/undriven opcode has no defined result, but the block must not lock up: the next valid opcode produces a correct result.
- Implementation is a combinational case decode feeding output registers. MUL and DIV must be single-cycle combinational (no multicycle stall).

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> out_o=0 and all flags 0. Release rst, then apply a=34, b=35, ADD -> next cycle out_o=69.
- Sweep opcodes 0..13 with a=34, b=35, one per cycle -> ADD/LW/SW/JMP/BEQ/BGT/BGE/LI give 69, SUB gives 0xFFFFFFFF, MUL 1190, DIV 0 (zero_o=1), AND 34, OR 35, XOR 1. Each result appears exactly one cycle after its opcode.
- Divide: a=100, b=7, DIV -> 14. Then a=7, b=0, DIV -> 0xFFFFFFFF with div_zero_o=1. Then ADD -> div_zero_o=0.
- Conditions:
  - a=35, b=34: BGT -> cond_o=1, out_o=69; BGE -> 1; BEQ -> 0.
  - a=b=5: BEQ -> 1, BGE -> 1, BGT -> 0.
  - a=0xFFFFFFFF (-1), b=1, BGT -> cond_o=0 (signed compare).
- Wrap/reserved: ADD 0xFFFFFFFF+1 -> out_o=0, zero_o=1. MUL 0x10000*0x10000 -> 0. Opcode 14 and 15 -> out_o=0, cond_o=0.
- Reset mid-stream: issue MUL at cycle n with rst=1 at the same edge -> outputs 0. The following cycle with rst=0 resumes normal results.

Source files
------------

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
//
// Registered integer ALU for the simple CPU datapath. It sits between the
// register-file read ports and the writeback / memory-address / branch logic.
// One operation is computed per cycle from two DATAWIDTH operands and a 4-bit
// opcode. All outputs are flops, so results appear exactly one cycle after
// their operands and opcode are sampled.
//
// Handshake: none. No valid/ready pair exists. A new operation is accepted
// on every rising edge of clk, and its result is valid on the outputs for the
// whole following cycle.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   a_i        in   DATAWIDTH  operand A
//   b_i        in   DATAWIDTH  operand B
//   opcode_i   in   4          operation select
//   out_o      out  DATAWIDTH  registered result
//   cond_o     out  1          registered branch condition (BEQ/BGT/BGE)
//   zero_o     out  1          registered: result equals 0
//   div_zero_o out  1          registered: DIV issued with b_i == 0
// ---------------------------------------------------------------------------
module alu_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic [3:0]           opcode_i,
  output logic [DATAWIDTH-1:0] out_o,
  output logic                 cond_o,
  output logic                 zero_o,
  output logic                 div_zero_o
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_LW    = 4'd7,
    OP_SW    = 4'd8,
    OP_JMP   = 4'd9,
    OP_BEQ   = 4'd10,
    OP_BGT   = 4'd11,
    OP_BGE   = 4'd12,
    OP_LI    = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_e;

  logic [DATAWIDTH-1:0] w_result;
  logic                 w_cond;
  logic                 w_div_zero;
  logic                 w_zero;
  logic [DATAWIDTH-1:0] w_sum;
  logic                 w_eq;
  logic                 w_sgt;

  logic [DATAWIDTH-1:0] r_out;
  logic                 r_cond;
  logic                 r_zero;
  logic                 r_div_zero;

  // The address-forming and branch ops all share one adder.
  assign w_sum = a_i + b_i;

  // Branch conditions compare the operands as two's-complement values.
  assign w_eq  = (a_i == b_i);
  assign w_sgt = ($signed(a_i) > $signed(b_i));

  // Combinational decode. The defaults cover the reserved opcodes and any
  // unknown opcode value, so an undriven opcode cannot leave stale state
  // behind: the next valid opcode produces a correct result.
  always_comb begin
    w_result   = '0;
    w_cond     = 1'b0;
    w_div_zero = 1'b0;
    case (opcode_i)
      OP_ADD: w_result = w_sum;
      OP_SUB: w_result = a_i - b_i;
      OP_MUL: w_result = a_i * b_i;            // low DATAWIDTH bits only
      OP_DIV: begin
        // Divide by zero saturates to all ones and raises the flag.
        if (b_i == '0) begin
          w_result   = '1;
          w_div_zero = 1'b1;
        end else begin
          w_result = a_i / b_i;
        end
      end
      OP_AND: w_result = a_i & b_i;
      OP_OR:  w_result = a_i | b_i;
      OP_XOR: w_result = a_i ^ b_i;
      OP_LW, OP_SW, OP_JMP, OP_LI: w_result = w_sum;
      OP_BEQ: begin
        w_result = w_sum;
        w_cond   = w_eq;
      end
      OP_BGT: begin
        w_result = w_sum;
        w_cond   = w_sgt;
      end
      OP_BGE: begin
        w_result = w_sum;
        w_cond   = w_sgt | w_eq;
      end
      default: begin
        w_result   = '0;
        w_cond     = 1'b0;
        w_div_zero = 1'b0;
      end
    endcase
  end

  // Zero flag tracks the value about to be registered, reserved ops included.
  assign w_zero = (w_result == '0);

  // Output registers. Reset wins over whatever operation is being sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_cond     <= 1'b0;
      r_zero     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_out      <= w_result;
      r_cond     <= w_cond;
      r_zero     <= w_zero;
      r_div_zero <= w_div_zero;
    end
  end

  assign out_o      = r_out;
  assign cond_o     = r_cond;
  assign zero_o     = r_zero;
  assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_unit
//
// Self-checking bench for alu_unit (DATAWIDTH = 32). Directed steps follow
// the block's behaviour list, followed by a randomized run. Expected values
// come from a reference function that uses plain 64-bit arithmetic on the
// operands. Each step pushes its expected outputs into exp_q, and the check
// after the next clock edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_alu_unit;

  localparam int W  = 32;
  localparam int EW = W + 3;   // {div_zero, zero, cond, out}

  logic         clk;
  logic         rst;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [3:0]   opcode_i;
  logic [W-1:0] out_o;
  logic         cond_o;
  logic         zero_o;
  logic         div_zero_o;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  alu_unit #(.DATAWIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_i        (a_i),
    .b_i        (b_i),
    .opcode_i   (opcode_i),
    .out_o      (out_o),
    .cond_o     (cond_o),
    .zero_o     (zero_o),
    .div_zero_o (div_zero_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // The operands are treated as plain integers and every result is reduced
  // modulo 2^W.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [3:0]   op,
                                          input logic         in_rst);
    longint unsigned m  = 64'd1 << W;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          sa = longint'(ua) - ((ua >= m / 2) ? longint'(m) : 64'sd0);
    longint          sb = longint'(ub) - ((ub >= m / 2) ? longint'(m) : 64'sd0);
    longint unsigned res = 0;
    logic cnd = 1'b0;
    logic dz  = 1'b0;
    logic [W-1:0] r;
    if (in_rst) return '0;
    case (int'(op))
      0, 7, 8, 9, 10, 11, 12, 13: res = (ua + ub) % m;
      1:  res = (ua + m - ub) % m;
      2:  res = (ua * ub) % m;
      3:  begin
            if (ub == 0) begin res = m - 1; dz = 1'b1; end
            else res = ua / ub;
          end
      4:  res = ua & ub;
      5:  res = ua | ub;
      6:  res = ua ^ ub;
      default: res = 0;
    endcase
    if (op == 4'd10) cnd = (sa == sb);
    if (op == 4'd11) cnd = (sa >  sb);
    if (op == 4'd12) cnd = (sa >= sb);
    r = res[W-1:0];
    return {dz, (res == 0), cnd, r};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".out"},  out_o, e[W-1:0]);
    chk({tag, ".cond"}, W'(cond_o), W'(e[W]));
    chk({tag, ".zero"}, W'(zero_o), W'(e[W+1]));
    chk({tag, ".dz"},   W'(div_zero_o), W'(e[W+2]));
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the rising edge sample, then check 1 ns later.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input logic r);
    @(negedge clk);
    a_i = a; b_i = b; opcode_i = op; rst = r;
    exp_q.push_back(model(a, b, op, r));
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Drives an undefined opcode with no expectation.
  task automatic step_x(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    a_i = a; b_i = b; opcode_i = 4'bxxxx; rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    rst = 1'b1; a_i = '0; b_i = '0; opcode_i = '0;

    // Reset held for two cycles with random inputs.
    step("rst0", $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    step("rst1", $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    step("add_first", 34, 35, 4'd0, 1'b0);

    // Opcode sweep.
    for (int op = 0; op < 14; op++)
      step($sformatf("sweep%0d", op), 34, 35, 4'(op), 1'b0);

    // Divide.
    step("div100_7", 100, 7, 4'd3, 1'b0);
    step("div_by0",  7,   0, 4'd3, 1'b0);
    step("add_after_div0", 7, 0, 4'd0, 1'b0);

    // Conditions.
    step("bgt_35_34", 35, 34, 4'd11, 1'b0);
    step("bge_35_34", 35, 34, 4'd12, 1'b0);
    step("beq_35_34", 35, 34, 4'd10, 1'b0);
    step("beq_5_5",   5,  5,  4'd10, 1'b0);
    step("bge_5_5",   5,  5,  4'd12, 1'b0);
    step("bgt_5_5",   5,  5,  4'd11, 1'b0);
    step("bgt_m1_1",  32'hFFFF_FFFF, 1, 4'd11, 1'b0);
    step("bge_1_m1",  1, 32'hFFFF_FFFF, 4'd12, 1'b0);

    // Wrap and reserved opcodes.
    step("add_wrap", 32'hFFFF_FFFF, 1, 4'd0, 1'b0);
    step("mul_wrap", 32'h0001_0000, 32'h0001_0000, 4'd2, 1'b0);
    step("rsv14", 34, 35, 4'd14, 1'b0);
    step("rsv15", 34, 35, 4'd15, 1'b0);

    // Reset in the middle of a stream.
    step("mul_pre",   6, 7, 4'd2, 1'b0);
    step("mul_inrst", 6, 7, 4'd2, 1'b1);
    step("mul_post",  6, 7, 4'd2, 1'b0);

    // Undefined opcode, then recovery.
    step_x(3, 4);
    step("after_x", 3, 4, 4'd1, 1'b0);

    // Randomized run with biased operand choices.
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = ra;
        2:       rb = W'($urandom_range(1, 20));
        3:       rb = -ra;
        default: rb = $urandom;
      endcase
      step($sformatf("rnd%0d", i), ra, rb, rop,
           ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
